// File: rtl/first_pkg.sv
// first_pkg: lamp encoding, controller states, dwell times and day-window bounds
// shared by the traffic controller and its request decoder.
package first_pkg;
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam int MIN_GREEN = 4;
    localparam int YEL       = 3;
    localparam int ALLRED    = 2;
    localparam int MAX_CG    = 8;

    localparam int DAY_START = 5;
    localparam int DAY_END   = 21;

    typedef enum logic [2:0] {HG, HY, AR, CG, CY} state_t;

    function automatic logic [1:0] hwy_lamp(input state_t s);
        return (s == HG) ? GREEN : (s == HY) ? YELLOW : RED;
    endfunction

    function automatic logic [1:0] country_lamp(input state_t s);
        return (s == CG) ? GREEN : (s == CY) ? YELLOW : RED;
    endfunction
endpackage

// File: rtl/first_req_decode.sv
// first_req_decode: day-window flag, night key qualification and the crossing request.
// Purely combinational; out-of-range times fall out as night.
module first_req_decode
    import first_pkg::*;
(
    input  logic       X,
    input  logic       B,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [7:0] char,
    output logic       is_true,
    output logic       is_true1,
    output logic       req
);
    assign is_true1 = (minutes <= 6'd59) &&
                      ((hours >= 5'(DAY_START) && hours < 5'(DAY_END)) ||
                       (hours == 5'(DAY_END) && minutes == 6'd0));
    assign is_true  = B && (char inside {8'h61, 8'h62, 8'h63});
    // Sensor by day, key by night.
    assign req      = is_true1 ? X : is_true;
endmodule

// File: rtl/first.sv
// first: highway/country-road traffic light controller with a dwell counter.
// Define FIRST_NIGHT_FLASH_EN to flash the country lamp red/yellow in night-time highway green.
module first
    import first_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    input  logic       B,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [7:0] char,
    output logic [1:0] hwy,
    output logic [1:0] country,
    output logic       is_true,
    output logic       is_true1
);
    logic       w_req;
    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;

    first_req_decode u_dec (
        .X        (X),
        .B        (B),
        .hours    (hours),
        .minutes  (minutes),
        .char     (char),
        .is_true  (is_true),
        .is_true1 (is_true1),
        .req      (w_req)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            HG:      w_next = (w_req && r_cnt >= 4'(MIN_GREEN - 1)) ? HY : HG;
            HY:      w_next = (r_cnt == 4'(YEL - 1)) ? AR : HY;
            AR:      w_next = (r_cnt == 4'(ALLRED - 1)) ? CG : AR;
            CG:      w_next = (!w_req || r_cnt == 4'(MAX_CG - 1)) ? CY : CG;
            CY:      w_next = (r_cnt == 4'(YEL - 1)) ? HG : CY;
            default: w_next = HG;
        endcase
    end

`ifdef FIRST_NIGHT_FLASH_EN
    logic r_flash;
    logic w_flash;
    assign w_flash = (r_state == HG) && (w_next == HG) && !is_true1;
`endif

    // Lamps are decoded from the next state so they switch with the state.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= HG;
            r_cnt   <= 4'd0;
            hwy     <= GREEN;
            country <= RED;
`ifdef FIRST_NIGHT_FLASH_EN
            r_flash <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
            hwy     <= hwy_lamp(w_next);
`ifdef FIRST_NIGHT_FLASH_EN
            r_flash <= w_flash ? ~r_flash : 1'b0;
            country <= w_flash ? (r_flash ? RED : YELLOW) : country_lamp(w_next);
`else
            country <= country_lamp(w_next);
`endif
        end
    end
endmodule

// File: tb/tb_first.sv
// tb_first: directed stimulus for the traffic controller with hand-computed lamp
// sequences and decode values, checked by immediate assertions.
module tb_first;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       X = 1'b0;
    logic       B = 1'b0;
    logic [4:0] hours = 5'd5;
    logic [5:0] minutes = 6'd0;
    logic [7:0] char = 8'h00;
    logic [1:0] hwy;
    logic [1:0] country;
    logic       is_true;
    logic       is_true1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10;

    first dut (
        .clock    (clock),
        .clear    (clear),
        .X        (X),
        .B        (B),
        .hours    (hours),
        .minutes  (minutes),
        .char     (char),
        .hwy      (hwy),
        .country  (country),
        .is_true  (is_true),
        .is_true1 (is_true1)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lamps(input string tag, input logic [1:0] h, input logic [1:0] c);
        chk({tag, ".hwy"}, 8'(hwy), 8'(h));
        chk({tag, ".country"}, 8'(country), 8'(c));
    endtask

    initial begin
        step(10);
        lamps("reset", G, R);
        clear = 1'b0;
        #1;
        chk("day_0500", 8'(is_true1), 8'd1);
        step(5);
        lamps("idle_day", G, R);
        // Sensor request with plenty of highway green already served
        X = 1'b1;
        for (int i = 0; i < 3; i++) begin step(1); lamps("hy", Y, R); end
        for (int i = 0; i < 2; i++) begin step(1); lamps("ar", R, R); end
        for (int i = 0; i < 6; i++) begin step(1); lamps("cg", R, G); end
        X = 1'b0;
        step(1); lamps("cy1", R, Y);
        step(1); lamps("cy2", R, Y);
        step(1); lamps("cy3", R, Y);
        // Request held across the return: minimum green then max country green
        X = 1'b1;
        step(1); lamps("hg_back", G, R);
        for (int i = 0; i < 3; i++) begin step(1); lamps("min_green", G, R); end
        step(1); lamps("hy_after_min", Y, R);
        step(5); lamps("cg_entry", R, G);
        step(7); lamps("cg_8th", R, G);
        step(1); lamps("cg_max_exit", R, Y);
        X = 1'b0;
        step(3); lamps("hg_after_max", G, R);
        // Day, wrong key
        hours = 5'd20; B = 1'b1; char = 8'h69;
        #1;
        chk("key_69", 8'(is_true), 8'd0);
        chk("day_2000", 8'(is_true1), 8'd1);
        step(6); lamps("day_idle_20", G, R);
        B = 1'b0;
        // Window boundaries
        hours = 5'd21; minutes = 6'd0;  #1; chk("win_2100", 8'(is_true1), 8'd1);
        hours = 5'd20; minutes = 6'd59; #1; chk("win_2059", 8'(is_true1), 8'd1);
        hours = 5'd4;  minutes = 6'd59; #1; chk("win_0459", 8'(is_true1), 8'd0);
        hours = 5'd10; minutes = 6'd60; #1; chk("win_min60", 8'(is_true1), 8'd0);
        // Night, sensor ignored
        hours = 5'd21; minutes = 6'd1; X = 1'b1;
        #1;
        chk("win_2101", 8'(is_true1), 8'd0);
        step(6);
        chk("night_x_ignored", 8'(hwy), 8'(G));
        // Night key runs the country sequence
        B = 1'b1; char = 8'h61;
        #1;
        chk("key_a", 8'(is_true), 8'd1);
        step(1); lamps("night_hy", Y, R);
        step(4); lamps("night_ar", R, R);
        step(1); lamps("night_cg", R, G);
        step(1); lamps("night_cg2", R, G);
        char = 8'h64;
        #1;
        chk("key_64", 8'(is_true), 8'd0);
        step(1); lamps("night_cy", R, Y);
        char = 8'h62; #1; chk("key_b", 8'(is_true), 8'd1);
        char = 8'h63; #1; chk("key_c", 8'(is_true), 8'd1);
        B = 1'b0; char = 8'h61; #1; chk("key_a_noB", 8'(is_true), 8'd0);
        X = 1'b0;
        step(3);
        chk("night_hg_back", 8'(hwy), 8'(G));
        // Clear while in all-red
        hours = 5'd12; minutes = 6'd0; X = 1'b1;
        step(4); lamps("pre_hy", Y, R);
        step(3); lamps("pre_ar", R, R);
        clear = 1'b1;
        step(1); lamps("clear_in_ar", G, R);
        clear = 1'b0; X = 1'b0; hours = 5'd24;
        #1;
        chk("hours24", 8'(is_true1), 8'd0);
        step(1);
        chk("after_clear", 8'(hwy), 8'(G));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
